// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for one single-ported unified memory.
// Optional misaligned-access trap: define MEM_ARB_MISALIGN_CHECK_EN.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic [DATA_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [2:0]            dm_mode,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  stall
);

  typedef enum logic [1:0] {
    IDLE, FETCH, DATA, RESP
  } state_e;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd3;
  localparam logic [2:0] LHU = 3'd4;
  localparam logic [2:0] SB  = 3'd5;
  localparam logic [2:0] SH  = 3'd6;
  localparam logic [2:0] SW  = 3'd7;

  state_e      state_q, state_d;
  logic        last_dm_q, last_dm_d;
  logic        ph_q, ph_d;
  logic [2:0]  mode_q, mode_d;
  logic [1:0]  lane_q, lane_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        ivld_q, ivld_d;
  logic [31:0] ird_q, ird_d;
  logic        dvld_q, dvld_d;
  logic        derr_q, derr_d;
  logic [31:0] drd_q, drd_d;

  logic        gnt_dm, gnt_if, mis, done, st;
  logic [1:0]  lane;
  logic [3:0]  st_be;
  logic [31:0] st_wd, sh, ld;

  assign gnt_dm = dm_req & (~if_req | ~last_dm_q);
  assign gnt_if = if_req & ~gnt_dm;
  assign st     = (dm_mode == SB) | (dm_mode == SH)
                | (dm_mode == SW);
  // The first access cycle is the address phase; data comes no earlier.
  assign done   = mem_ready & ph_q;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic is_h, is_w;
  assign is_h = (dm_mode == LH) | (dm_mode == LHU)
              | (dm_mode == SH);
  assign is_w = (dm_mode == LW) | (dm_mode == SW);
  assign mis  = (is_h & dm_addr[0])
              | (is_w & |dm_addr[1:0]);
`else
  assign mis  = 1'b0;
`endif

  always_comb begin
    lane = 2'b00;
    case (dm_mode)
      LB, LBU, SB: lane = dm_addr[1:0];
      LH, LHU, SH: lane = {dm_addr[1], 1'b0};
      default:     lane = 2'b00;
    endcase
  end

  always_comb begin
    st_be = 4'b0000;
    st_wd = dm_wdata;
    case (dm_mode)
      SB: begin
        st_be = 4'b0001 << lane;
        st_wd = {4{dm_wdata[7:0]}};
      end
      SH: begin
        st_be = 4'b0011 << lane;
        st_wd = {2{dm_wdata[15:0]}};
      end
      SW:      st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  assign sh = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld = '0;
    case (mode_q)
      LB:      ld = {{24{sh[7]}}, sh[7:0]};
      LH:      ld = {{16{sh[15]}}, sh[15:0]};
      LW:      ld = mem_rdata;
      LBU:     ld = {24'b0, sh[7:0]};
      LHU:     ld = {16'b0, sh[15:0]};
      default: ld = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_dm_q <= 1'b0;
      ph_q      <= 1'b0;
      mode_q    <= 3'd0;
      lane_q    <= 2'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wd_q      <= '0;
      ivld_q    <= 1'b0;
      ird_q     <= '0;
      dvld_q    <= 1'b0;
      derr_q    <= 1'b0;
      drd_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_dm_q <= last_dm_d;
      ph_q      <= ph_d;
      mode_q    <= mode_d;
      lane_q    <= lane_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wd_q      <= wd_d;
      ivld_q    <= ivld_d;
      ird_q     <= ird_d;
      dvld_q    <= dvld_d;
      derr_q    <= derr_d;
      drd_q     <= drd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_dm_d = last_dm_q;
    ph_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_dm) begin
          last_dm_d = 1'b1;
          state_d   = mis ? RESP : DATA;
        end else if (gnt_if) begin
          last_dm_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH, DATA: begin
        ph_d = ~done;
        if (done) state_d = RESP;
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d = mode_q;
    lane_d = lane_q;
    req_d  = req_q;
    we_d   = we_q;
    addr_d = addr_q;
    be_d   = be_q;
    wd_d   = wd_q;
    ivld_d = 1'b0;
    ird_d  = ird_q;
    dvld_d = 1'b0;
    derr_d = 1'b0;
    drd_d  = drd_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_dm & mis: begin
            dvld_d = 1'b1;
            derr_d = 1'b1;
            drd_d  = '0;
          end
          gnt_dm & ~mis: begin
            mode_d = dm_mode;
            lane_d = lane;
            req_d  = 1'b1;
            we_d   = st;
            addr_d = dm_addr & ~32'h3;
            be_d   = st_be;
            wd_d   = st ? st_wd : '0;
          end
          gnt_if: begin
            req_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = if_addr & ~32'h3;
            be_d   = 4'b0000;
            wd_d   = '0;
          end
          default: ;
        endcase
      end
      FETCH, DATA: begin
        if (done) begin
          req_d  = 1'b0;
          we_d   = 1'b0;
          addr_d = '0;
          be_d   = 4'b0000;
          wd_d   = '0;
          if (state_q == FETCH) begin
            ivld_d = 1'b1;
            ird_d  = mem_rdata;
          end else begin
            dvld_d = 1'b1;
            drd_d  = ld;
          end
        end
      end
      RESP: ;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wd_q;
  assign if_valid  = ivld_q;
  assign if_rdata  = ird_q;
  assign dm_valid  = dvld_q;
  assign dm_err    = derr_q;
  assign dm_rdata  = drd_q;
  assign stall     = (if_req & ~ivld_q)
                   | (dm_req & ~dvld_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter.
// Covers latency, lanes, round-robin, wait states and async reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_mode;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;

  int nvec = 0;
  int nerr = 0;

  mem_port_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_mode(dm_mode),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run_txn(
    input  logic        dm,
    input  logic [2:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        got_req,
    output logic [31:0] o_addr,
    output logic [3:0]  o_be,
    output logic        o_we,
    output logic [31:0] o_wd,
    output logic        got_vld,
    output logic [31:0] o_rd,
    output logic        o_err,
    output logic        other);
    got_req = 0; got_vld = 0; other = 0;
    o_addr = '0; o_be = '0; o_we = 0;
    o_wd = '0; o_rd = '0; o_err = 0;
    mem_rdata = rdata;
    if (dm) begin
      dm_req = 1; dm_mode = mode;
      dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr;
    end
    for (int c = 0; c < 20 && !got_vld; c++) begin
      @(negedge clk);
      if (dm ? if_valid : dm_valid) other = 1;
      if (mem_req && !got_req) begin
        got_req = 1;
        o_addr = mem_addr; o_be = mem_be;
        o_we = mem_we; o_wd = mem_wdata;
      end
      if (dm ? dm_valid : if_valid) begin
        got_vld = 1;
        o_rd  = dm ? dm_rdata : if_rdata;
        o_err = dm_err;
      end
    end
    dm_req = 0; if_req = 0;
    @(negedge clk);
  endtask

  logic        g_req, g_vld, g_we, g_err, g_oth;
  logic [31:0] g_addr, g_wd, g_rd;
  logic [3:0]  g_be;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt.push_back('{0, 3'd0, 32'h10, 32'h0,
      32'h00500093, 32'h10, 4'h0, 0, 32'h00500093});
    vt.push_back('{1, 3'd5, 32'h103, 32'hAB,
      32'hDEADBEEF, 32'h100, 4'h8, 1, 32'h0});
    vt.push_back('{1, 3'd0, 32'h102, 32'h0,
      32'h12F03456, 32'h100, 4'h0, 0, 32'hFFFFFFF0});
    vt.push_back('{1, 3'd4, 32'h102, 32'h0,
      32'h12F03456, 32'h100, 4'h0, 0, 32'h000012F0});
    vt.push_back('{1, 3'd1, 32'h100, 32'h0,
      32'h12348001, 32'h100, 4'h0, 0, 32'hFFFF8001});
    vt.push_back('{1, 3'd3, 32'h101, 32'h0,
      32'h12F03456, 32'h100, 4'h0, 0, 32'h00000034});
    vt.push_back('{1, 3'd2, 32'h204, 32'h0,
      32'hCAFEBABE, 32'h204, 4'h0, 0, 32'hCAFEBABE});
    vt.push_back('{1, 3'd6, 32'h102, 32'h0000BEEF,
      32'h0, 32'h100, 4'hC, 1, 32'h0});
    vt.push_back('{1, 3'd7, 32'h208, 32'h11223344,
      32'h0, 32'h208, 4'hF, 1, 32'h0});
    vt.push_back('{1, 3'd5, 32'h100, 32'hFFFFFF5A,
      32'h0, 32'h100, 4'h1, 1, 32'h0});
    vt.push_back('{1, 3'd0, 32'h103, 32'h0,
      32'h7F000000, 32'h100, 4'h0, 0, 32'h0000007F});
    vt.push_back('{1, 3'd4, 32'h100, 32'h0,
      32'hFFFF8001, 32'h100, 4'h0, 0, 32'h00008001});
`ifndef MEM_ARB_MISALIGN_CHECK_EN
    vt.push_back('{1, 3'd2, 32'h206, 32'h0,
      32'hA5A5C3C3, 32'h204, 4'h0, 0, 32'hA5A5C3C3});
    vt.push_back('{1, 3'd1, 32'h103, 32'h0,
      32'h87654321, 32'h100, 4'h0, 0, 32'hFFFF8765});
`endif

    rst_n = 0; if_req = 0; dm_req = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    dm_mode = '0; mem_rdata = '0; mem_ready = 1;
    #12;
    chk("rst_ctl", {mem_req, mem_we, mem_be,
        if_valid, dm_valid, dm_err, stall}, '0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_ird", if_rdata, '0);
    chk("rst_drd", dm_rdata, '0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // fetch latency with mem_ready tied high
    if_req = 1; if_addr = 32'h10;
    mem_rdata = 32'h00500093;
    #1 chk("lat_n", {mem_req, stall, if_valid}, 3'b010);
    @(negedge clk);
    chk("lat_n1", {mem_req, stall, if_valid}, 3'b110);
    chk("lat_n1_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk("lat_n2", {mem_req, stall, if_valid}, 3'b110);
    @(negedge clk);
    chk("lat_n3", {mem_req, stall, if_valid}, 3'b001);
    chk("lat_n3_rd", if_rdata, 32'h00500093);
    if_req = 0;
    @(negedge clk);
    chk("lat_n4", {if_valid, mem_req}, 2'b00);

    foreach (vt[i]) begin
      mem_ready = 1;
      run_txn(vt[i].dm, vt[i].mode, vt[i].addr,
              vt[i].wdata, vt[i].rdata, g_req,
              g_addr, g_be, g_we, g_wd, g_vld,
              g_rd, g_err, g_oth);
      chk($sformatf("v%0d_req", i), g_req, 1);
      chk($sformatf("v%0d_addr", i), g_addr,
          vt[i].e_addr);
      chk($sformatf("v%0d_be_we", i), {g_be, g_we},
          {vt[i].e_be, vt[i].e_we});
      if (vt[i].e_we) begin
        case (vt[i].mode)
          3'd5: chk($sformatf("v%0d_wd", i), g_wd,
                    {4{vt[i].wdata[7:0]}});
          3'd6: chk($sformatf("v%0d_wd", i), g_wd,
                    {2{vt[i].wdata[15:0]}});
          default: chk($sformatf("v%0d_wd", i),
                       g_wd, vt[i].wdata);
        endcase
      end
      chk($sformatf("v%0d_vld", i), g_vld, 1);
      chk($sformatf("v%0d_rd", i), g_rd, vt[i].e_rd);
      chk($sformatf("v%0d_err_oth", i),
          {g_err, g_oth}, 2'b00);
    end

    // wait states: mem_* and stall must hold
    begin
      logic seen = 0;
      mem_ready = 0;
      dm_req = 1; dm_mode = 3'd7;
      dm_addr = 32'h40; dm_wdata = 32'h12345678;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (mem_req) seen = 1;
      end
      chk("hold_req_seen", seen, 1);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk($sformatf("hold%0d_ctl", k),
            {mem_req, mem_we, mem_be, stall, dm_valid},
            8'b1111_1110);
        chk($sformatf("hold%0d_addr", k), mem_addr,
            32'h40);
        chk($sformatf("hold%0d_wd", k), mem_wdata,
            32'h12345678);
      end
      mem_ready = 1;
      @(negedge clk);
      chk("hold_rel", {dm_valid, mem_req, stall},
          3'b100);
      chk("hold_rel_rd", dm_rdata, '0);
      dm_req = 0;
      @(negedge clk);
      chk("hold_pulse", dm_valid, 0);
    end

    // async reset while a data access is outstanding
    begin
      logic seen = 0;
      mem_ready = 0;
      dm_req = 1; dm_mode = 3'd2; dm_addr = 32'h80;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (mem_req) seen = 1;
      end
      chk("arst_req_seen", seen, 1);
      #2 rst_n = 0;
      #1 chk("arst_async", {mem_req, dm_valid}, 2'b00);
      dm_req = 0;
      @(negedge clk); rst_n = 1; mem_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("arst_idle", {mem_req, dm_valid, if_valid},
          3'b000);
      run_txn(0, 3'd0, 32'h20, 32'h0, 32'h00000013,
              g_req, g_addr, g_be, g_we, g_wd, g_vld,
              g_rd, g_err, g_oth);
      chk("arst_fetch_vld", g_vld, 1);
      chk("arst_fetch_rd", g_rd, 32'h00000013);
    end

    // both pending after an IF grant: DM wins first
    begin
      logic idone = 0, ddone = 0, both = 0;
      logic gq = 0;
      logic [31:0] fa = '0;
      logic [1:0]  first = 0;
      mem_ready = 1; mem_rdata = 32'h55;
      if_req = 1; if_addr = 32'h30;
      dm_req = 1; dm_mode = 3'd2; dm_addr = 32'h300;
      for (int c = 0; c < 40 && !(idone && ddone);
           c++) begin
        @(negedge clk);
        if (if_valid && dm_valid) both = 1;
        if (mem_req && !gq) begin
          gq = 1; fa = mem_addr;
        end
        if (dm_valid && !ddone) begin
          ddone = 1;
          if (!idone) first = 2'd1;
          dm_req = 0;
        end
        if (if_valid && !idone) begin
          idone = 1;
          if (!ddone) first = 2'd2;
          if_req = 0;
        end
      end
      chk("rr_done", {idone, ddone}, 2'b11);
      chk("rr_first_addr", fa, 32'h300);
      chk("rr_order", first, 2'd1);
      chk("rr_overlap", both, 0);
      @(negedge clk);
    end

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    begin
      logic sreq = 0, got = 0, err = 0;
      logic [31:0] rd = '1;
      mem_ready = 1;
      dm_req = 1; dm_mode = 3'd2; dm_addr = 32'h101;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (mem_req) sreq = 1;
        if (dm_valid && !got) begin
          got = 1; err = dm_err; rd = dm_rdata;
          dm_req = 0;
        end
      end
      chk("mis_noreq", sreq, 0);
      chk("mis_vld", got, 1);
      chk("mis_err", err, 1);
      chk("mis_rd", rd, '0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
